// File: rtl/ttt_pkg.sv
// Shared types and codes for the tic-tac-toe turn controller.
package ttt_pkg;

   localparam int NUM_CELLS = 9;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      X_TURN  = 3'd1,
      X_WRITE = 3'd2,
      O_TURN  = 3'd3,
      O_WRITE = 3'd4,
      CHECK   = 3'd5,
      DONE    = 3'd6
   } state_t;

   // Board cell codes
   localparam logic [1:0] EMPTY  = 2'b00;
   localparam logic [1:0] CELL_X = 2'b01;
   localparam logic [1:0] CELL_O = 2'b10;

   // Game result codes
   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_X    = 2'b01;
   localparam logic [1:0] RES_O    = 2'b10;
   localparam logic [1:0] RES_DRAW = 2'b11;

   // Turn indication reuses the cell code of the player to move
   function automatic logic [1:0] turn_of(input state_t s);
      case (s)
         X_TURN:  turn_of = CELL_X;
         O_TURN:  turn_of = CELL_O;
         default: turn_of = EMPTY;
      endcase
   endfunction

endpackage

// File: rtl/ttt_turn_ctrl_move_check.sv
// Combinational move legality check and one-hot cell decode.
// A position is legal when it is 1..9 and the addressed cell is empty.
module ttt_move_check
   import ttt_pkg::*;
(
   input  logic [3:0]             pos_i,
   input  logic [2*NUM_CELLS-1:0] board_i,
   output logic                   legal_o,
   output logic [NUM_CELLS-1:0]   onehot_o
);

   // Decode pos to a strobe and look up the addressed cell
   always_comb begin
      legal_o  = 1'b0;
      onehot_o = '0;
      for (int k = 0; k < NUM_CELLS; k++) begin
         if (pos_i == 4'(k + 1)) begin
            onehot_o[k] = 1'b1;
            legal_o     = (board_i[2*k +: 2] == EMPTY);
         end
      end
   end

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Turn sequencer and move arbiter for the tic-tac-toe core.
// Optional turn timer is enabled by defining TTT_TIMEOUT_EN; without it the
// timeout output is tied low and TURN_TIMEOUT has no effect.
module ttt_turn_ctrl
   import ttt_pkg::*;
#(
   parameter int unsigned TURN_TIMEOUT = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   play_i,
   input  logic                   x_req_i,
   input  logic [3:0]             x_pos_i,
   input  logic                   o_req_i,
   input  logic [3:0]             o_pos_i,
   input  logic [2*NUM_CELLS-1:0] board_i,
   input  logic [1:0]             win_i,
   input  logic                   nospc_i,
   output logic [NUM_CELLS-1:0]   x_pos_en_o,
   output logic [NUM_CELLS-1:0]   o_pos_en_o,
   output logic                   board_clr_o,
   output logic                   x_ack_o,
   output logic                   o_ack_o,
   output logic                   x_err_o,
   output logic                   o_err_o,
   output logic [1:0]             turn_o,
   output logic [1:0]             result_o,
   output logic [3:0]             move_cnt_o,
   output logic                   timeout_o
);

   state_t               state_q, state_d;
   logic                 nxt_o_q, nxt_o_d;     // O moves after the pending CHECK
   logic [1:0]           result_q, result_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [NUM_CELLS-1:0] x_en_q, x_en_d, o_en_q, o_en_d;
   logic                 clr_q, clr_d;
   logic                 x_ack_q, x_ack_d, o_ack_q, o_ack_d;
   logic                 x_err_q, x_err_d, o_err_q, o_err_d;
   logic [1:0]           turn_q, turn_d;

   logic                   o_sel, req_sel, mv_legal;
   logic [3:0]             pos_sel;
   logic [2*NUM_CELLS-1:0] chk_board;
   logic [NUM_CELLS-1:0]   mv_onehot;

   // One checker shared by both players; the board write of the clear strobe
   // lands only at the end of the first turn cycle, so mask the board then.
   assign o_sel     = (state_q == O_TURN);
   assign req_sel   = o_sel ? o_req_i : x_req_i;
   assign pos_sel   = o_sel ? o_pos_i : x_pos_i;
   assign chk_board = clr_q ? '0 : board_i;

   ttt_move_check u_move_check (
      .pos_i    (pos_sel),
      .board_i  (chk_board),
      .legal_o  (mv_legal),
      .onehot_o (mv_onehot)
   );

`ifdef TTT_TIMEOUT_EN
   localparam int TW = (TURN_TIMEOUT > 2) ? $clog2(TURN_TIMEOUT) : 1;

   logic [TW-1:0] timer_q, timer_d;
   logic          in_turn, expire;
   logic          timeout_q, timeout_d;

   assign in_turn = (state_q == X_TURN) || (state_q == O_TURN);
   assign expire  = in_turn && (timer_q == TW'(TURN_TIMEOUT - 1));

   // Turn timer restarts on every state change and idles outside turns
   always_comb begin
      timer_d = '0;
      if (state_d == state_q && in_turn) timer_d = timer_q + 1'b1;
   end

   // Timer and timeout pulse registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timer_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   logic unused_turn_timeout;
   assign unused_turn_timeout = (TURN_TIMEOUT == 0);
   assign timeout_o           = 1'b0;
`endif

   // Next-state and next-output logic; every output is registered
   always_comb begin
      state_d  = state_q;
      nxt_o_d  = nxt_o_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      x_en_d   = '0;
      o_en_d   = '0;
      clr_d    = 1'b0;
      x_ack_d  = 1'b0;
      o_ack_d  = 1'b0;
      x_err_d  = 1'b0;
      o_err_d  = 1'b0;
`ifdef TTT_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (play_i) begin
               clr_d    = 1'b1;
               cnt_d    = '0;
               result_d = RES_NONE;
               state_d  = X_TURN;
            end
         end
         X_TURN: begin
            if (x_req_i) begin
               if (mv_legal) begin
                  x_en_d  = mv_onehot;
                  x_ack_d = 1'b1;
                  cnt_d   = cnt_q + 4'd1;
                  nxt_o_d = 1'b1;
                  state_d = X_WRITE;
               end else begin
                  x_err_d = 1'b1;
               end
            end
         end
         O_TURN: begin
            if (o_req_i) begin
               if (mv_legal) begin
                  o_en_d  = mv_onehot;
                  o_ack_d = 1'b1;
                  cnt_d   = cnt_q + 4'd1;
                  nxt_o_d = 1'b0;
                  state_d = O_WRITE;
               end else begin
                  o_err_d = 1'b1;
               end
            end
         end
         X_WRITE, O_WRITE: state_d = CHECK;
         CHECK: begin
            if (win_i != RES_NONE) begin
               result_d = win_i;
               state_d  = DONE;
            end else if (nospc_i) begin
               result_d = RES_DRAW;
               state_d  = DONE;
            end else begin
               state_d = nxt_o_q ? O_TURN : X_TURN;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef TTT_TIMEOUT_EN
      // A legal move on the expiry cycle takes precedence over the forfeit
      if (expire && !(req_sel && mv_legal)) begin
         timeout_d = 1'b1;
         state_d   = (state_q == X_TURN) ? O_TURN : X_TURN;
      end
`endif
      turn_d = turn_of(state_d);
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         nxt_o_q  <= 1'b0;
         result_q <= RES_NONE;
         cnt_q    <= '0;
         x_en_q   <= '0;
         o_en_q   <= '0;
         clr_q    <= 1'b0;
         x_ack_q  <= 1'b0;
         o_ack_q  <= 1'b0;
         x_err_q  <= 1'b0;
         o_err_q  <= 1'b0;
         turn_q   <= EMPTY;
      end else begin
         state_q  <= state_d;
         nxt_o_q  <= nxt_o_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         x_en_q   <= x_en_d;
         o_en_q   <= o_en_d;
         clr_q    <= clr_d;
         x_ack_q  <= x_ack_d;
         o_ack_q  <= o_ack_d;
         x_err_q  <= x_err_d;
         o_err_q  <= o_err_d;
         turn_q   <= turn_d;
      end
   end

   assign x_pos_en_o  = x_en_q;
   assign o_pos_en_o  = o_en_q;
   assign board_clr_o = clr_q;
   assign x_ack_o     = x_ack_q;
   assign o_ack_o     = o_ack_q;
   assign x_err_o     = x_err_q;
   assign o_err_o     = o_err_q;
   assign turn_o      = turn_q;
   assign result_o    = result_q;
   assign move_cnt_o  = cnt_q;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Directed bench for ttt_turn_ctrl with a board-register and winner model.
module tb_ttt_turn_ctrl;

`ifdef TTT_TIMEOUT_EN
   localparam int unsigned TO = 8;
`else
   localparam int unsigned TO = 255;
`endif

   logic        clk = 1'b0;
   logic        rst, play, x_req, o_req;
   logic [3:0]  x_pos, o_pos;
   logic [17:0] board = '0;
   logic [1:0]  win;
   logic        nospc;
   logic [8:0]  x_pos_en, o_pos_en;
   logic        board_clr, x_ack, o_ack, x_err, o_err, timeout;
   logic [1:0]  turn, result;
   logic [3:0]  move_cnt;

   int tests = 0;
   int fails = 0;

   ttt_turn_ctrl #(.TURN_TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst), .play_i(play),
      .x_req_i(x_req), .x_pos_i(x_pos), .o_req_i(o_req), .o_pos_i(o_pos),
      .board_i(board), .win_i(win), .nospc_i(nospc),
      .x_pos_en_o(x_pos_en), .o_pos_en_o(o_pos_en), .board_clr_o(board_clr),
      .x_ack_o(x_ack), .o_ack_o(o_ack), .x_err_o(x_err), .o_err_o(o_err),
      .turn_o(turn), .result_o(result), .move_cnt_o(move_cnt), .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   // Board register model driven by the DUT strobes
   always @(posedge clk) begin
      if (board_clr) board <= '0;
      else begin
         for (int k = 0; k < 9; k++) begin
            if (x_pos_en[k])      board[2*k +: 2] <= 2'b01;
            else if (o_pos_en[k]) board[2*k +: 2] <= 2'b10;
         end
      end
   end

   function automatic logic [1:0] win_of(input logic [17:0] b);
      int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
      win_of = 2'b00;
      for (int i = 0; i < 8; i++) begin
         if (b[2*ln[i][0] +: 2] != 2'b00 &&
             b[2*ln[i][0] +: 2] == b[2*ln[i][1] +: 2] &&
             b[2*ln[i][0] +: 2] == b[2*ln[i][2] +: 2])
            win_of = b[2*ln[i][0] +: 2];
      end
   endfunction

   function automatic logic full_of(input logic [17:0] b);
      full_of = 1'b1;
      for (int k = 0; k < 9; k++) if (b[2*k +: 2] == 2'b00) full_of = 1'b0;
   endfunction

   assign win   = win_of(board);
   assign nospc = full_of(board);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue a legal move at a negedge in the TURN state; returns at the
   // negedge following CHECK (next TURN or DONE).
   task automatic move(input bit is_o, input int p, input int cnt);
      if (is_o) begin o_req = 1'b1; o_pos = 4'(p); end
      else      begin x_req = 1'b1; x_pos = 4'(p); end
      @(negedge clk);
      chk(is_o ? "o_ack" : "x_ack", 32'(is_o ? o_ack : x_ack), 32'd1);
      chk("pos_en", 32'(is_o ? o_pos_en : x_pos_en), 32'd1 << (p - 1));
      chk("other_en", 32'(is_o ? x_pos_en : o_pos_en), 32'd0);
      chk("err_on_move", 32'(x_err | o_err), 32'd0);
      chk("cnt_move", 32'(move_cnt), 32'(cnt));
      chk("turn_write", 32'(turn), 32'd0);
      x_req = 1'b0;
      o_req = 1'b0;
      @(negedge clk);
      chk("turn_check", 32'(turn), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int seq [9] = '{5, 1, 9, 3, 2, 8, 4, 6, 7};
      rst = 1'b1; play = 1'b0; x_req = 1'b0; o_req = 1'b0; x_pos = '0; o_pos = '0;
      repeat (2) @(negedge clk);
      chk("rst_turn", 32'(turn), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_cnt", 32'(move_cnt), 32'd0);
      chk("rst_en", 32'({x_pos_en, o_pos_en}), 32'd0);
      chk("rst_misc", 32'({board_clr, x_ack, o_ack, x_err, o_err, timeout}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_turn", 32'(turn), 32'd0);

      // Game 1: start, illegal moves, X wins on top row
      play = 1'b1;
      @(negedge clk);
      play = 1'b0;
      chk("clr_start", 32'(board_clr), 32'd1);
      chk("turn_x0", 32'(turn), 32'd1);
      @(negedge clk);
      chk("clr_once", 32'(board_clr), 32'd0);
      x_req = 1'b1; x_pos = 4'd0;
      @(negedge clk);
      chk("err_pos0", 32'(x_err), 32'd1);
      @(negedge clk);
      chk("err_held", 32'(x_err), 32'd1);
      x_pos = 4'd12;
      @(negedge clk);
      chk("err_pos12", 32'(x_err), 32'd1);
      chk("err_no_en", 32'(x_pos_en), 32'd0);
      chk("err_turn", 32'(turn), 32'd1);
      x_req = 1'b0;
      @(negedge clk);
      chk("err_drop", 32'(x_err), 32'd0);
      chk("board_after_err", 32'(board), 32'd0);
      o_req = 1'b1; o_pos = 4'd7;
      @(negedge clk);
      chk("o_ignored", 32'({o_ack, o_err, o_pos_en}), 32'd0);
      chk("o_ign_turn", 32'(turn), 32'd1);
      o_req = 1'b0;
      move(0, 1, 1); chk("turn_o1", 32'(turn), 32'd2);
      move(1, 4, 2); chk("turn_x1", 32'(turn), 32'd1);
      move(0, 2, 3); chk("turn_o2", 32'(turn), 32'd2);
      move(1, 5, 4); chk("turn_x2", 32'(turn), 32'd1);
      move(0, 3, 5);
      chk("win_result", 32'(result), 32'd1);
      chk("win_cnt", 32'(move_cnt), 32'd5);
      chk("win_turn", 32'(turn), 32'd0);
      x_req = 1'b1; x_pos = 4'd7;
      repeat (2) @(negedge clk);
      chk("done_ignore", 32'({x_ack, x_err, x_pos_en}), 32'd0);
      chk("done_hold", 32'({result, turn}), 32'({2'b01, 2'b00}));
      x_req = 1'b0;

      // Game 2: restart from DONE; first-cycle move sees an empty board
      play = 1'b1;
      @(negedge clk);
      play = 1'b0;
      chk("restart_clr", 32'(board_clr), 32'd1);
      chk("restart_cnt", 32'({result, move_cnt}), 32'd0);
      move(0, 5, 1);
      chk("g2_turn_o", 32'(turn), 32'd2);
      o_req = 1'b1; o_pos = 4'd5; x_req = 1'b1; x_pos = 4'd6;
      @(negedge clk);
      chk("o_err_occ", 32'(o_err), 32'd1);
      chk("o_err_noen", 32'({o_ack, o_pos_en, x_ack, x_pos_en}), 32'd0);
      chk("o_err_turn", 32'(turn), 32'd2);
      move(1, 1, 2);
      chk("g2_turn_x", 32'(turn), 32'd1);

      // Reset during X_WRITE
      x_req = 1'b1; x_pos = 4'd9;
      @(negedge clk);
      chk("pre_rst_ack", 32'({x_ack, x_pos_en}), 32'({1'b1, 9'h100}));
      rst = 1'b1; x_req = 1'b0;
      @(negedge clk);
      chk("rst_write_out", 32'({x_pos_en, o_pos_en, x_ack, board_clr}), 32'd0);
      chk("rst_write_st", 32'({turn, result, move_cnt}), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst", 32'({x_pos_en, o_pos_en, turn}), 32'd0);

      // Game 3: full draw
      play = 1'b1;
      @(negedge clk);
      play = 1'b0;
      chk("g3_clr", 32'(board_clr), 32'd1);
      for (int i = 0; i < 9; i++) begin
         move(i[0], seq[i], i + 1);
         if (i < 8) chk("draw_turn", 32'(turn), i[0] ? 32'd1 : 32'd2);
      end
      chk("draw_result", 32'(result), 32'd3);
      chk("draw_cnt", 32'(move_cnt), 32'd9);
      chk("draw_turn_done", 32'(turn), 32'd0);
      chk("no_timeout", 32'(timeout), 32'd0);

`ifdef TTT_TIMEOUT_EN
      // X idles out; then O moves legally on its expiry cycle
      play = 1'b1;
      @(negedge clk);
      play = 1'b0;
      repeat (7) @(negedge clk);
      chk("to_before", 32'({timeout, turn}), 32'({1'b0, 2'b01}));
      @(negedge clk);
      chk("to_pulse", 32'(timeout), 32'd1);
      chk("to_turn", 32'(turn), 32'd2);
      chk("to_cnt", 32'(move_cnt), 32'd0);
      @(negedge clk);
      chk("to_once", 32'(timeout), 32'd0);
      repeat (6) @(negedge clk);
      o_req = 1'b1; o_pos = 4'd5;
      @(negedge clk);
      o_req = 1'b0;
      chk("to_race_ack", 32'(o_ack), 32'd1);
      chk("to_race_to", 32'(timeout), 32'd0);
      chk("to_race_cnt", 32'(move_cnt), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

endmodule
